// File: rtl/lfsr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lfsr_pkg: PRBS polynomial taps, checker state encoding, bit-serial step fn |
// | Rev 1.1                                                                    |
// +----------------------------------------------------------------------------+
package lfsr_pkg;

  localparam int LFSR_MAX_DEGREE = 32;
  localparam int PRBS_MAX_WIDTH  = 64;

  // Tap vectors: bit k-1 set means term x^k is present in the polynomial.
  localparam logic [6:0]  PRBS7  = 7'h60;         // x^7  + x^6  + 1
  localparam logic [8:0]  PRBS9  = 9'h110;        // x^9  + x^5  + 1
  localparam logic [14:0] PRBS15 = 15'h6000;      // x^15 + x^14 + 1
  localparam logic [22:0] PRBS23 = 23'h420000;    // x^23 + x^18 + 1
  localparam logic [30:0] PRBS31 = 31'h48000000;  // x^31 + x^28 + 1

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbs_chk_state_e;

  typedef struct packed {
    logic [PRBS_MAX_WIDTH-1:0]  mismatch;
    logic [LFSR_MAX_DEGREE-1:0] state;
  } prbs_step_t;

  // Walks data[0..width-1] in time order; the newest bit enters state[0].
  function automatic prbs_step_t prbs_step(
    input logic [LFSR_MAX_DEGREE-1:0] state,
    input logic [LFSR_MAX_DEGREE-1:0] taps,
    input logic [PRBS_MAX_WIDTH-1:0]  data,
    input logic                       self_sync,
    input int                         degree,
    input int                         width
  );
    prbs_step_t                 r;
    logic [LFSR_MAX_DEGREE-1:0] s;
    logic [LFSR_MAX_DEGREE-1:0] mask;
    logic                       e;
    logic                       nb;
    r    = '0;
    s    = state;
    mask = '0;
    for (int k = 0; k < LFSR_MAX_DEGREE; k++) begin
      if (k < degree) mask[k] = 1'b1;
    end
    for (int i = 0; i < PRBS_MAX_WIDTH; i++) begin
      if (i < width) begin
        e             = ^(s & taps);
        r.mismatch[i] = e ^ data[i];
        nb            = self_sync ? data[i] : e;
        s             = {s[LFSR_MAX_DEGREE-2:0], nb} & mask;
      end
    end
    r.state = s;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_checker_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prbs_checker_if: beat stream in, lock status and error reporting out       |
// | Rev 1.1                                                                    |
// +----------------------------------------------------------------------------+
interface prbs_checker_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ERR_CNT_WIDTH = 32
);
  logic                     s_valid;
  logic [DATA_WIDTH-1:0]    s_data;
  logic                     clear_counters;
  logic                     locked;
  logic                     err_valid;
  logic [DATA_WIDTH-1:0]    err_mask;
  logic [ERR_CNT_WIDTH-1:0] bit_err_cnt;
  logic [ERR_CNT_WIDTH-1:0] beat_err_cnt;
  logic                     lock_lost;

  modport master (
    output s_valid, s_data, clear_counters,
    input  locked, err_valid, err_mask, bit_err_cnt, beat_err_cnt, lock_lost
  );

  modport slave (
    input  s_valid, s_data, clear_counters,
    output locked, err_valid, err_mask, bit_err_cnt, beat_err_cnt, lock_lost
  );
endinterface
`default_nettype wire

// File: rtl/prbs_checker_err_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prbs_err_counter: saturating accumulator with clear and enable             |
// | Rev 1.1                                                                    |
// +----------------------------------------------------------------------------+
module prbs_err_counter #(
  parameter int IN_WIDTH  = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 en_i,
  input  logic [IN_WIDTH-1:0]  inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);
  localparam int SUM_W = ((CNT_WIDTH > IN_WIDTH) ? CNT_WIDTH : IN_WIDTH) + 1;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0]     sum;
  logic [SUM_W-1:0]     max_ext;

  always_comb begin
    sum     = SUM_W'(cnt_q) + SUM_W'(inc_i);
    max_ext = SUM_W'({CNT_WIDTH{1'b1}});
    cnt_d   = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      // Clamp rather than wrap when the add would pass all-ones.
      cnt_d = (sum > max_ext) ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule
`default_nettype wire

// File: rtl/prbs_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prbs_checker: HUNT/VERIFY/LOCKED PRBS lock with saturating error counts    |
// | Rev 1.1                                                                    |
// +----------------------------------------------------------------------------+
module prbs_checker
  import lfsr_pkg::*;
#(
  parameter int                     POLY_DEGREE   = 7,
  parameter logic [POLY_DEGREE-1:0] POLYNOMIAL    = PRBS7,
  parameter int                     DATA_WIDTH    = 8,
  parameter int                     LOCK_COUNT    = 4,
  parameter int                     UNLOCK_COUNT  = 4,
  parameter int                     ERR_CNT_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  prbs_checker_if.slave bus
);
  localparam int FILL    = (POLY_DEGREE + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int CNT_MAX = (FILL > LOCK_COUNT) ?
                           ((FILL > UNLOCK_COUNT) ? FILL : UNLOCK_COUNT) :
                           ((LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int POP_W   = $clog2(DATA_WIDTH + 1);

  prbs_chk_state_e         state_q, state_d;
  logic [POLY_DEGREE-1:0]  lfsr_q, lfsr_d;
  logic [CNT_W-1:0]        run_cnt_q, run_cnt_d;
  logic                    locked_q;
  logic                    err_valid_q;
  logic [DATA_WIDTH-1:0]   err_mask_q;
  logic                    lock_lost_q;

  logic [LFSR_MAX_DEGREE-1:0] taps_ext, state_ext;
  logic [PRBS_MAX_WIDTH-1:0]  data_ext;
  prbs_step_t                 step;
  logic [DATA_WIDTH-1:0]      mismatch;
  logic                       beat_err;
  logic [POP_W-1:0]           popcount;
  logic                       count_en;
  logic                       unused_step;
  logic [ERR_CNT_WIDTH-1:0]   bit_cnt, beat_cnt;

  always_comb begin
    taps_ext                     = '0;
    taps_ext[POLY_DEGREE-1:0]    = POLYNOMIAL;
    state_ext                    = '0;
    state_ext[POLY_DEGREE-1:0]   = lfsr_q;
    data_ext                     = '0;
    data_ext[DATA_WIDTH-1:0]     = bus.s_data;
    // Only LOCKED free-runs, so a flipped bit is not re-multiplied by the taps.
    step     = prbs_step(state_ext, taps_ext, data_ext, state_q != LOCKED,
                         POLY_DEGREE, DATA_WIDTH);
    mismatch = step.mismatch[DATA_WIDTH-1:0];
    beat_err = |mismatch;
    popcount = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      popcount = popcount + POP_W'(mismatch[i]);
    end
  end

  assign unused_step = ^{step.mismatch, step.state};
  assign count_en    = bus.s_valid && (state_q == LOCKED);

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    run_cnt_d = run_cnt_q;
    if (bus.s_valid) begin
      lfsr_d = step.state[POLY_DEGREE-1:0];
      case (state_q)
        HUNT: begin
          if (run_cnt_q == CNT_W'(FILL - 1)) begin
            state_d   = VERIFY;
            run_cnt_d = '0;
          end else begin
            run_cnt_d = run_cnt_q + 1'b1;
          end
        end
        VERIFY: begin
          if (beat_err) begin
            run_cnt_d = '0;
          end else if (run_cnt_q == CNT_W'(LOCK_COUNT - 1)) begin
            state_d   = LOCKED;
            run_cnt_d = '0;
          end else begin
            run_cnt_d = run_cnt_q + 1'b1;
          end
        end
        LOCKED: begin
          if (!beat_err) begin
            run_cnt_d = '0;
          end else if (run_cnt_q == CNT_W'(UNLOCK_COUNT - 1)) begin
            state_d   = HUNT;
            run_cnt_d = '0;
          end else begin
            run_cnt_d = run_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d   = HUNT;
          run_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      lfsr_q      <= '0;
      run_cnt_q   <= '0;
      locked_q    <= 1'b0;
      err_valid_q <= 1'b0;
      err_mask_q  <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      run_cnt_q   <= run_cnt_d;
      locked_q    <= (state_d == LOCKED);
      err_valid_q <= bus.s_valid;
      err_mask_q  <= count_en ? mismatch : '0;
      lock_lost_q <= count_en && (state_d == HUNT);
    end
  end

  prbs_err_counter #(.IN_WIDTH(POP_W), .CNT_WIDTH(ERR_CNT_WIDTH)) u_bit_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear_i (bus.clear_counters),
    .en_i    (count_en),
    .inc_i   (popcount),
    .cnt_o   (bit_cnt)
  );

  prbs_err_counter #(.IN_WIDTH(1), .CNT_WIDTH(ERR_CNT_WIDTH)) u_beat_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear_i (bus.clear_counters),
    .en_i    (count_en),
    .inc_i   (beat_err),
    .cnt_o   (beat_cnt)
  );

  assign bus.locked       = locked_q;
  assign bus.err_valid    = err_valid_q;
  assign bus.err_mask     = err_mask_q;
  assign bus.lock_lost    = lock_lost_q;
  assign bus.bit_err_cnt  = bit_cnt;
  assign bus.beat_err_cnt = beat_cnt;
endmodule
`default_nettype wire

// File: tb/tb_prbs_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_prbs_checker: directed PRBS7 stimulus on 32-bit and 4-bit counter DUTs  |
// | Rev 1.1                                                                    |
// +----------------------------------------------------------------------------+
module tb_prbs_checker;
  import lfsr_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [6:0] g;

  prbs_checker_if #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(32)) bus32 ();
  prbs_checker_if #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(4))  bus4 ();

  prbs_checker #(.POLY_DEGREE(7), .POLYNOMIAL(PRBS7), .DATA_WIDTH(8),
                 .LOCK_COUNT(4), .UNLOCK_COUNT(4), .ERR_CNT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  prbs_checker #(.POLY_DEGREE(7), .POLYNOMIAL(PRBS7), .DATA_WIDTH(8),
                 .LOCK_COUNT(4), .UNLOCK_COUNT(4), .ERR_CNT_WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference PRBS7 source (x^7 + x^6 + 1), bit 0 of each beat first in time.
  task automatic gen(output logic [7:0] d);
    logic b;
    for (int i = 0; i < 8; i++) begin
      b    = g[6] ^ g[5];
      d[i] = b;
      g    = {g[5:0], b};
    end
  endtask

  // Called at a negedge; returns at the negedge after the consuming posedge.
  task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic c);
    rst                  = r;
    bus32.s_valid        = v;
    bus32.s_data         = d;
    bus32.clear_counters = c;
    bus4.s_valid         = v;
    bus4.s_data          = d;
    bus4.clear_counters  = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clean_beat(input logic c);
    logic [7:0] d;
    gen(d);
    cyc(1'b0, 1'b1, d, c);
  endtask

  initial begin
    logic [7:0] d;
    logic       v;
    int         nvalid;
    total = 0;
    bad   = 0;
    g     = 7'h7F;
    rst   = 1'b1;
    bus32.s_valid = 1'b0; bus32.s_data = '0; bus32.clear_counters = 1'b0;
    bus4.s_valid  = 1'b0; bus4.s_data  = '0; bus4.clear_counters  = 1'b0;
    @(negedge clk);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);

    chk("rst_locked",    bus32.locked,       0);
    chk("rst_err_valid", bus32.err_valid,    0);
    chk("rst_err_mask",  bus32.err_mask,     0);
    chk("rst_bit_cnt",   bus32.bit_err_cnt,  0);
    chk("rst_beat_cnt",  bus32.beat_err_cnt, 0);
    chk("rst_lock_lost", bus32.lock_lost,    0);

    // Initial lock: 1 HUNT beat + 4 clean VERIFY beats
    repeat (4) clean_beat(1'b0);
    chk("lock_not_yet_4", bus32.locked, 0);
    clean_beat(1'b0);
    chk("lock_after_5",   bus32.locked,       1);
    chk("lock_err_valid", bus32.err_valid,    1);
    chk("lock_bit_cnt",   bus32.bit_err_cnt,  0);
    chk("lock_beat_cnt",  bus32.beat_err_cnt, 0);

    // Single flipped bit while locked
    repeat (2) clean_beat(1'b0);
    gen(d);
    cyc(1'b0, 1'b1, d ^ 8'h08, 1'b0);
    chk("flip_mask",     bus32.err_mask,     8'h08);
    chk("flip_bit_cnt",  bus32.bit_err_cnt,  1);
    chk("flip_beat_cnt", bus32.beat_err_cnt, 1);
    chk("flip_locked",   bus32.locked,       1);
    clean_beat(1'b0);
    chk("flip_mask_next", bus32.err_mask,    8'h00);
    chk("flip_bit_hold",  bus32.bit_err_cnt, 1);

    // Four inverted beats drop lock
    clean_beat(1'b1);
    chk("clr_bit_cnt", bus32.bit_err_cnt, 0);
    repeat (3) begin
      gen(d);
      cyc(1'b0, 1'b1, ~d, 1'b0);
    end
    chk("inv3_locked",    bus32.locked,    1);
    chk("inv3_lock_lost", bus32.lock_lost, 0);
    gen(d);
    cyc(1'b0, 1'b1, ~d, 1'b0);
    chk("inv4_lock_lost", bus32.lock_lost,    1);
    chk("inv4_locked",    bus32.locked,       0);
    chk("inv4_bit_cnt",   bus32.bit_err_cnt,  32);
    chk("inv4_beat_cnt",  bus32.beat_err_cnt, 4);
    chk("inv4_mask",      bus32.err_mask,     8'hFF);
    clean_beat(1'b0);
    chk("relost_pulse_end", bus32.lock_lost, 0);
    chk("hunt_mask",        bus32.err_mask,  8'h00);
    repeat (3) clean_beat(1'b0);
    chk("relock_not_yet", bus32.locked, 0);
    clean_beat(1'b0);
    chk("relock",          bus32.locked,      1);
    chk("retain_bit_cnt",  bus32.bit_err_cnt, 32);

    // Reset while locked with two errored beats pending
    repeat (2) begin
      gen(d);
      cyc(1'b0, 1'b1, ~d, 1'b0);
    end
    chk("pend_locked", bus32.locked, 1);
    gen(d);
    cyc(1'b1, 1'b1, ~d, 1'b0);
    chk("mid_rst_locked",    bus32.locked,       0);
    chk("mid_rst_err_valid", bus32.err_valid,    0);
    chk("mid_rst_mask",      bus32.err_mask,     0);
    chk("mid_rst_bit_cnt",   bus32.bit_err_cnt,  0);
    chk("mid_rst_beat_cnt",  bus32.beat_err_cnt, 0);
    chk("mid_rst_lock_lost", bus32.lock_lost,    0);

    // Random idle gaps; garbage data on idle cycles must be ignored
    nvalid = 0;
    for (int i = 0; i < 80 && nvalid < 8; i++) begin
      v = 1'($urandom_range(0, 1));
      if (v) gen(d);
      else   d = 8'($urandom);
      cyc(1'b0, v, d, 1'b0);
      if (v) nvalid++;
      chk("gap_err_valid", bus32.err_valid, v);
      chk("gap_locked",    bus32.locked,    nvalid >= 5);
      chk("gap_mask",      bus32.err_mask,  0);
    end
    chk("gap_budget", nvalid >= 8, 1);

    // Saturation on the 4-bit counter instance
    clean_beat(1'b1);
    repeat (20) begin
      gen(d);
      cyc(1'b0, 1'b1, d ^ 8'h01, 1'b0);
      clean_beat(1'b0);
    end
    chk("sat4_bit_cnt",   bus4.bit_err_cnt,   4'hF);
    chk("sat4_beat_cnt",  bus4.beat_err_cnt,  4'hF);
    chk("w32_bit_cnt",    bus32.bit_err_cnt,  20);
    chk("w32_beat_cnt",   bus32.beat_err_cnt, 20);
    chk("sat_locked",     bus4.locked,        1);

    // Clear wins over a same-cycle error
    gen(d);
    cyc(1'b0, 1'b1, d ^ 8'h04, 1'b1);
    chk("clr4_bit_cnt",  bus4.bit_err_cnt,   0);
    chk("clr4_beat_cnt", bus4.beat_err_cnt,  0);
    chk("clr32_bit_cnt", bus32.bit_err_cnt,  0);
    chk("clr32_beat",    bus32.beat_err_cnt, 0);
    chk("clr_mask",      bus4.err_mask,      8'h04);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
